// File: rtl/aes_dec_pipe_scheduler_if.sv
// Handshake, key and datapath-control bundle between the AES decrypt scheduler and its environment.
// master = scheduler side, slave = key source / block producer / consumer / datapath side.
interface aes_dec_pipe_scheduler_if #(
    parameter int TAG_WIDTH = 4
);
    logic [127:0]          key_in;
    logic                  key_load;
    logic                  key_busy;
    logic                  key_ready;
    logic                  in_valid;
    logic                  in_ready;
    logic [127:0]          in_data;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [127:0]          out_data;
    logic [TAG_WIDTH-1:0]  out_tag;
    logic [5:0]            occupancy;
    logic [127:0]          dp_key;
    logic                  dp_key_start;
    logic [127:0]          dp_data;
    logic                  dp_enable;
    logic [127:0]          dp_result;

    modport master (
        input  key_in, key_load, in_valid, in_data, in_tag, out_ready, dp_result,
        output key_busy, key_ready, in_ready, out_valid, out_data, out_tag, occupancy,
               dp_key, dp_key_start, dp_data, dp_enable
    );

    modport slave (
        output key_in, key_load, in_valid, in_data, in_tag, out_ready, dp_result,
        input  key_busy, key_ready, in_ready, out_valid, out_data, out_tag, occupancy,
               dp_key, dp_key_start, dp_data, dp_enable
    );
endinterface

// File: rtl/aes_dec_pipe_scheduler.sv
// Sequencer for the pipelined AES-128 decrypt datapath: key generation, tagged block
// streaming with a global stall on back-pressure, and drain-before-rekey.
//
// state   | meaning
// IDLE    | no valid key; waiting for key_load
// KEY_GEN | dp_key_start held high while round keys are generated
// RUN     | blocks accepted and streamed; re-key request moves to DRAIN
// DRAIN   | pipeline flushed with bubbles until occupancy reaches 0
module aes_dec_pipe_scheduler #(
    parameter int PIPE_DEPTH    = 32,
    parameter int KEYGEN_CYCLES = 23,
    parameter int TAG_WIDTH     = 4
) (
    input logic clock,
    input logic reset_n,
    aes_dec_pipe_scheduler_if.master bus
);
    typedef enum logic [1:0] {IDLE, KEY_GEN, RUN, DRAIN} stateType;

    localparam logic [4:0] KEYGEN_LOAD = 5'(KEYGEN_CYCLES - 1);

    stateType                 state, nextState;
    logic [4:0]               keyCnt;
    logic [127:0]             dpKey, shadowKey, dpData;
    logic                     rekeyPending;
    logic [PIPE_DEPTH-1:0]    validPipe;
    logic [TAG_WIDTH-1:0]     tagPipe [PIPE_DEPTH];
    logic [5:0]               occ;
    logic                     outValid, dpEnable, inReady, accept, fire;

    assign outValid = validPipe[PIPE_DEPTH-1];
    // The whole datapath freezes while the consumer refuses a presented block.
    assign dpEnable = ((state == RUN) || (state == DRAIN)) && !(outValid && !bus.out_ready);
    assign inReady  = (state == RUN) && dpEnable && !rekeyPending;
    assign accept   = bus.in_valid && inReady;
    assign fire     = outValid && bus.out_ready;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.key_load) nextState = KEY_GEN;
            KEY_GEN: if (keyCnt == 5'd0) nextState = RUN;
            RUN:     if (bus.key_load) nextState = DRAIN;
            DRAIN:   if (occ == 6'd0) nextState = KEY_GEN;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            keyCnt       <= 5'd0;
            dpKey        <= '0;
            shadowKey    <= '0;
            rekeyPending <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (bus.key_load) begin
                        dpKey  <= bus.key_in;
                        keyCnt <= KEYGEN_LOAD;
                    end
                end
                KEY_GEN: begin
                    if (keyCnt != 5'd0) keyCnt <= keyCnt - 5'd1;
                end
                RUN: begin
                    if (bus.key_load) begin
                        shadowKey    <= bus.key_in;
                        rekeyPending <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (occ == 6'd0) begin
                        dpKey        <= shadowKey;
                        rekeyPending <= 1'b0;
                        keyCnt       <= KEYGEN_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            validPipe <= '0;
            dpData    <= '0;
        end else if (dpEnable) begin
            validPipe <= {validPipe[PIPE_DEPTH-2:0], accept};
            if (accept) dpData <= bus.in_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_DEPTH; i++) tagPipe[i] <= '0;
        end else if (dpEnable) begin
            tagPipe[0] <= bus.in_tag;
            for (int i = 1; i < PIPE_DEPTH; i++) tagPipe[i] <= tagPipe[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occ <= 6'd0;
        end else begin
            case ({accept, fire})
                2'b10:   occ <= occ + 6'd1;
                2'b01:   occ <= occ - 6'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign bus.key_busy     = (state == KEY_GEN) || (state == DRAIN) || ((state == RUN) && rekeyPending);
    assign bus.key_ready    = (state == RUN);
    assign bus.dp_key_start = (state == KEY_GEN);
    assign bus.dp_enable    = dpEnable;
    assign bus.in_ready     = inReady;
    assign bus.out_valid    = outValid;
    assign bus.out_tag      = tagPipe[PIPE_DEPTH-1];
    assign bus.out_data     = bus.dp_result;
    assign bus.occupancy    = occ;
    assign bus.dp_key       = dpKey;
    assign bus.dp_data      = dpData;
endmodule

// File: tb/tb_aes_dec_pipe_scheduler.sv
// Scoreboard bench for aes_dec_pipe_scheduler with a stand-in datapath whose result is
// the captured block XOR the generated key, delayed to the scheduler's output slot.
module tb_aes_dec_pipe_scheduler;
    localparam int TW = 4;
    localparam int PD = 32;
    localparam int KG = 23;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    aes_dec_pipe_scheduler_if #(.TAG_WIDTH(TW)) bus ();

    aes_dec_pipe_scheduler #(.PIPE_DEPTH(PD), .KEYGEN_CYCLES(KG), .TAG_WIDTH(TW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    // Stand-in datapath: dp_data register is the first stage, PD-1 further stages follow.
    logic [127:0] stage [PD-1];
    logic [127:0] genKey = '0;
    always @(posedge clock) begin
        if (bus.dp_enable) begin
            stage[0] <= bus.dp_data;
            for (int i = 1; i < PD - 1; i++) stage[i] <= stage[i-1];
        end
    end
    always @(posedge clock) if (bus.dp_key_start) genKey <= bus.dp_key;
    assign bus.dp_result = stage[PD-2] ^ genKey;

    typedef struct {
        logic [127:0]  data;
        logic [TW-1:0] tag;
    } expT;

    expT          expQ[$];
    logic [127:0] activeKey = '0;
    int           checks = 0;
    int           failures = 0;

    task automatic checkEq(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: occupancy model, ordered result check, hold stability, key-gen length.
    logic [127:0]  holdData;
    logic [TW-1:0] holdTag;
    bit            holdValid = 0;
    int            runLen = 0;
    always @(negedge clock) begin
        if (!reset_n) begin
            expQ.delete();
            holdValid = 0;
            runLen = 0;
        end else begin
            checkEq("occupancy", 128'(bus.occupancy), 128'(expQ.size()));
            if (holdValid) begin
                checkEq("hold_data", bus.out_data, holdData);
                checkEq("hold_tag", 128'(bus.out_tag), 128'(holdTag));
            end
            if (expQ.size() == 0) begin
                checkEq("spurious_out_valid", 128'(bus.out_valid), 128'(0));
            end else if (bus.out_valid && bus.out_ready) begin
                expT e;
                e = expQ.pop_front();
                checkEq("out_data", bus.out_data, e.data);
                checkEq("out_tag", 128'(bus.out_tag), 128'(e.tag));
            end
            if (bus.out_valid && !bus.out_ready)
                checkEq("stall_enable", 128'(bus.dp_enable), 128'(0));
            holdValid = bus.out_valid && !bus.out_ready;
            holdData  = bus.out_data;
            holdTag   = bus.out_tag;
            if (bus.in_valid && bus.in_ready)
                expQ.push_back('{bus.in_data ^ activeKey, bus.in_tag});
            if (bus.dp_key_start) begin
                runLen++;
                checkEq("keygen_enable_low", 128'(bus.dp_enable), 128'(0));
            end else if (runLen != 0) begin
                checkEq("keygen_len", 128'(runLen), 128'(KG));
                runLen = 0;
            end
        end
    end

    task automatic checkResetOutputs(input string name);
        checkEq({name, "_ctrl"}, 128'({bus.key_busy, bus.key_ready, bus.in_ready, bus.out_valid,
                 bus.occupancy, bus.dp_key_start, bus.dp_enable, bus.out_tag}), 128'(0));
        checkEq({name, "_dp_key"}, bus.dp_key, 128'(0));
        checkEq({name, "_dp_data"}, bus.dp_data, 128'(0));
    endtask

    // Loads a key from IDLE and returns cycles until key_ready.
    task automatic loadKey(input logic [127:0] k, output int n);
        activeKey    = k;
        bus.key_in   = k;
        bus.key_load = 1'b1;
        tick();
        bus.key_load = 1'b0;
        n = 0;
        while (!bus.key_ready && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic drain(input string name);
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while ((expQ.size() != 0 || bus.occupancy != 0) && n < 400) begin
            tick();
            n++;
        end
        checkEq({name, "_drained"}, 128'(expQ.size()), 128'(0));
    endtask

    initial begin
        int n, maxOcc, sent, cyc;
        bit pending;
        logic [127:0] k2;

        bus.key_in = '0; bus.key_load = 1'b0; bus.in_valid = 1'b0;
        bus.in_data = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
        repeat (3) tick();
        checkResetOutputs("reset");
        reset_n = 1'b1;
        tick();

        // 1: key load timing and single-block latency
        loadKey(128'h000102030405060708090a0b0c0d0e0f, n);
        checkEq("t1_keygen_cycles", 128'(n), 128'(KG));
        checkEq("t1_key_ready", 128'(bus.key_ready), 128'(1));
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        bus.in_tag    = 4'd3;
        tick();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        checkEq("t1_latency", 128'(n), 128'(PD));
        checkEq("t1_data", bus.out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a ^ activeKey);
        checkEq("t1_tag", 128'(bus.out_tag), 128'(3));
        drain("t1");

        // 2: 40 back-to-back blocks
        maxOcc = 0;
        for (int i = 0; i < 40; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = rnd128();
            bus.in_tag   = TW'(i % 16);
            #1;
            checkEq("t2_in_ready", 128'(bus.in_ready), 128'(1));
            tick();
            if (int'(bus.occupancy) > maxOcc) maxOcc = int'(bus.occupancy);
        end
        checkEq("t2_max_occupancy", 128'(maxOcc), 128'(PD));
        drain("t2");

        // 2b: random gaps on both sides
        sent = 0; cyc = 0; pending = 0;
        while (sent < 60 && cyc < 3000) begin
            if (!pending && $urandom_range(0, 3) != 0) begin
                pending     = 1;
                bus.in_data = rnd128();
                bus.in_tag  = TW'($urandom);
            end
            bus.in_valid  = pending;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.in_valid && bus.in_ready) begin
                pending = 0;
                sent++;
            end
            tick();
            cyc++;
        end
        checkEq("t2b_sent", 128'(sent), 128'(60));
        drain("t2b");

        // 3: back-pressure at first result
        bus.out_ready = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            bus.in_valid = 1'b1;
            bus.in_data  = rnd128();
            bus.in_tag   = TW'($urandom);
            tick();
            n++;
        end
        checkEq("t3_out_valid", 128'(bus.out_valid), 128'(1));
        for (int i = 0; i < 10; i++) begin
            checkEq("t3_dp_enable", 128'(bus.dp_enable), 128'(0));
            checkEq("t3_in_ready", 128'(bus.in_ready), 128'(0));
            tick();
        end
        drain("t3");

        // 4: re-key with 5 blocks in flight
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = rnd128();
            bus.in_tag   = TW'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        k2 = rnd128();
        bus.key_in   = k2;
        bus.key_load = 1'b1;
        tick();
        bus.key_load = 1'b0;
        activeKey    = k2;
        checkEq("t4_in_ready", 128'(bus.in_ready), 128'(0));
        checkEq("t4_key_busy", 128'(bus.key_busy), 128'(1));
        n = 0;
        while (!bus.key_ready && n < 300) begin
            tick();
            n++;
        end
        checkEq("t4_key_ready", 128'(bus.key_ready), 128'(1));
        checkEq("t4_results_out", 128'(expQ.size()), 128'(0));
        checkEq("t4_dp_key", bus.dp_key, k2);
        bus.in_valid = 1'b1;
        bus.in_data  = rnd128();
        bus.in_tag   = 4'd9;
        tick();
        drain("t4");

        // 5: reset mid-stream at occupancy 12
        bus.out_ready = 1'b1;
        n = 0;
        while (bus.occupancy != 12 && n < 100) begin
            bus.in_valid = 1'b1;
            bus.in_data  = rnd128();
            bus.in_tag   = TW'($urandom);
            tick();
            n++;
        end
        checkEq("t5_occupancy", 128'(bus.occupancy), 128'(12));
        reset_n = 1'b0;
        #1;
        checkResetOutputs("t5_reset");
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkEq("t5_out_valid", 128'(bus.out_valid), 128'(0));
            checkEq("t5_in_ready", 128'(bus.in_ready), 128'(0));
        end
        bus.in_valid = 1'b0;

        // 6: key_load during KEY_GEN is ignored
        activeKey    = 128'h3c3c_0123_4567_89ab_cdef_fedc_ba98_7654;
        bus.key_in   = activeKey;
        bus.key_load = 1'b1;
        tick();
        bus.key_load = 1'b0;
        n = 0;
        repeat (5) begin
            tick();
            n++;
        end
        bus.key_in   = ~activeKey;
        bus.key_load = 1'b1;
        tick();
        n++;
        bus.key_load = 1'b0;
        while (!bus.key_ready && n < 200) begin
            tick();
            n++;
        end
        checkEq("t6_keygen_cycles", 128'(n), 128'(KG));
        checkEq("t6_key_retained", bus.dp_key, activeKey);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = rnd128();
            bus.in_tag   = TW'(i + 5);
            tick();
        end
        drain("t6");

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/aes_dec_pipe_scheduler.md
Name: aes_dec_pipe_scheduler

Overview:
- Controller that sequences the 32-stage pipelined AES-128 decryption datapath and its key_creation round-key generator.
- Accepts a key-load request, runs key generation for a fixed cycle count, then streams tagged ciphertext blocks into the pipeline with valid/ready handshakes.
- Tracks block validity and tags alongside the pipeline and stalls the whole datapath through its global enable when the consumer back-pressures.
- Drains in-flight blocks before any re-key.

Parameters:
- PIPE_DEPTH, 32, number of enabled clock edges from dp_data capture to the matching dp_result.
- KEYGEN_CYCLES, 23, cycles dp_key_start is held high before round keys are valid.
- TAG_WIDTH, 4, width of the sideband tag carried with each block.

Ports:
- clock  in  1  system clock, all state on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- key_in  in  128  cipher key, sampled on key_load acceptance.
- key_load  in  1  request to (re)load the key.
- key_busy  out  1  high in KEY_GEN and DRAIN, and in RUN while a re-key is pending.
- key_ready  out  1  high only in RUN.
- in_valid  in  1  ciphertext block valid.
- in_ready  out  1  block accepted when in_valid && in_ready.
- in_data  in  128  ciphertext block.
- in_tag  in  TAG_WIDTH  sideband tag.
- out_valid  out  1  plaintext valid.
- out_ready  in  1  consumer ready.
- out_data  out  128  plaintext, equal to dp_result.
- out_tag  out  TAG_WIDTH  tag of the block on out_data.
- occupancy  out  6  count of valid blocks in flight, 0..PIPE_DEPTH.
- dp_key  out  128  key to the generator.
- dp_key_start  out  1  generator start (startTransition of key_creation).
- dp_data  out  128  pipeline input.
- dp_enable  out  1  pipeline-wide startTransition; low freezes every stage.
- dp_result  in  128  pipeline output (last AddRoundKey stage).

Behaviour:
- Reset (async, reset_n=0):
  - State returns to IDLE.
  - All outputs reset to 0: key_busy, key_ready, in_ready, out_valid, occupancy, dp_key_start, dp_enable, dp_key, dp_data, out_tag.
  - Valid and tag shift registers are cleared. Blocks in flight are discarded with no output.
  - Reset mid-KEY_GEN or mid-DRAIN aborts; a fresh key_load is required.
- State IDLE: key_load=1 latches key_in into dp_key and moves to KEY_GEN. in_ready=0.
- State KEY_GEN:
  - dp_key_start=1 for exactly KEYGEN_CYCLES cycles, counted by a 5-bit counter, then drops to 0.
  - The next state is RUN. dp_enable=0 throughout. key_load is ignored.
- State RUN:
  - dp_enable = !(out_valid && !out_ready).
  - in_ready = dp_enable && !rekey_pending.
  - On every edge with dp_enable=1:
    - The valid shift register (PIPE_DEPTH bits) shifts in (in_valid && in_ready).
    - The tag shift register shifts in in_tag.
    - dp_data is registered from in_data on accept; otherwise it holds and is marked as a bubble.
  - With dp_enable=0, all shift registers and dp_data hold.
- Outputs:
  - out_valid = MSB of the valid shift register; out_tag = MSB tag.
  - out_data = dp_result, combinational pass-through.
  - Block N appears exactly PIPE_DEPTH enabled edges after its accept edge.
- Occupancy:
  - +1 on accept, -1 when out_valid && out_ready.
  - Both in the same cycle leaves it unchanged.
  - It never exceeds PIPE_DEPTH, because the pipeline stalls rather than overflowing.
- Re-key:
  - key_load=1 in RUN sets rekey_pending and latches key_in into a shadow register.
  - in_ready drops the following cycle, and the state moves to DRAIN.
- State DRAIN:
  - The pipeline advances with bubbles under the same stall rule; key_busy=1.
  - When occupancy==0, the shadow key is copied to dp_key, rekey_pending is cleared, and the state moves to KEY_GEN.
  - If occupancy is already 0 on the request, DRAIN lasts one cycle.
- key_load while in KEY_GEN or DRAIN is ignored. A simultaneous key_load and accept in RUN accepts the block first.
- Back-pressure: out_valid stays high and out_data/out_tag stay stable until out_ready. No block is dropped or duplicated.

Test Plan:
1. Reset; key_load with key 000102030405060708090a0b0c0d0e0f; after 23 cycles key_ready=1. Then inject in_data 69c4e0d86a7b0430d8cdb78070b4c55a, tag 3 -> 32 cycles later out_valid=1, out_data 00112233445566778899aabbccddeeff, out_tag 3.
2. Stream 40 back-to-back blocks, tags 0..15 wrapping, with out_ready=1 -> outputs in order with matching tags, occupancy saturates at 32, in_ready never drops.
3. Hold out_ready=0 when the first result arrives -> dp_enable=0, in_ready=0, out_data stable for 10 cycles; release -> stream resumes with no loss and no duplicate.
4. Issue key_load with a second key while 5 blocks are in flight -> in_ready=0, the 5 results emerge, then KEY_GEN for 23 cycles; next block decrypts correctly under the new key.
5. Assert reset_n=0 mid-stream with occupancy 12 -> all outputs 0 immediately, state IDLE; after release out_valid stays 0 and in_ready stays 0 until a new key_load.
6. Pulse key_load during KEY_GEN -> ignored, KEY_GEN length unchanged at 23 cycles, original key retained.
